// File: rtl/alu_mul_seq_if.sv
// -----------------------------------------------------------------------------
// alu_mul_seq_if
//
// Bundles the request/response handshake of the shift-and-add multiply
// sequencer together with its borrowed-ALU bus.
//
//   Request / response
//     start       requester -> sequencer  start request (taken when ready=1)
//     op_a        requester -> sequencer  multiplicand
//     op_b        requester -> sequencer  multiplier
//     ready       sequencer -> requester  idle, can take a request
//     done        sequencer -> requester  one-cycle completion pulse
//     result      sequencer -> requester  low WIDTH bits of the last product
//
//   Shared ALU
//     alu_own     sequencer -> datapath   datapath must route alu_* to the ALU
//     alu_control sequencer -> ALU        ALU operation code
//     alu_src_a   sequencer -> ALU        operand A
//     alu_src_b   sequencer -> ALU        operand B
//     alu_result  ALU -> sequencer        combinational ALU result
//
// The slave modport is the sequencer's view; the master modport is the view
// of the surrounding datapath (requester plus ALU).
// -----------------------------------------------------------------------------
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             alu_own;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_src_a;
  logic [WIDTH-1:0] alu_src_b;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  start,
    input  op_a,
    input  op_b,
    input  alu_result,
    output ready,
    output done,
    output result,
    output alu_own,
    output alu_control,
    output alu_src_a,
    output alu_src_b
  );

  modport master (
    output start,
    output op_a,
    output op_b,
    output alu_result,
    input  ready,
    input  done,
    input  result,
    input  alu_own,
    input  alu_control,
    input  alu_src_a,
    input  alu_src_b
  );
endinterface

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
//
// Multi-cycle sequencer producing the low WIDTH bits of op_a * op_b (the
// RV32M MUL result). It owns no adder or multiplier: every addition and every
// multiplicand shift is performed by the processor's shared ALU, which this
// block borrows while alu_own=1. Only the multiplier shift-right is local.
//
// Ports
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     alu_mul_seq_if.slave, carrying:
//             start/op_a/op_b/ready        request handshake
//             done/result                  completion pulse and held product
//             alu_own/alu_control/
//             alu_src_a/alu_src_b          drive for the shared ALU
//             alu_result                   value returned by the ALU
//
// Algorithm (one ALU operation per cycle)
//   ADD   : prod  <= prod + mcand          (only when the multiplier LSB is 1)
//   SHIFT : mcand <= mcand << 1, mplier <= mplier >> 1
// The walk stops as soon as the remaining multiplier is zero, so the cost is
// popcount(op_b) + (msb index of op_b + 1) cycles after acceptance.
// -----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] OP_ADD = 4'b0000,
  parameter logic [3:0] OP_LS  = 4'b0111
) (
  input  logic         clk,
  input  logic         resetn,
  alu_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q,   prod_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             alu_own_c;
  logic [3:0]       alu_control_c;
  logic [WIDTH-1:0] alu_src_a_c;
  logic [WIDTH-1:0] alu_src_b_c;

  // Chooses where the walk goes for a given remaining multiplier: finished
  // when nothing is left, otherwise accumulate if the current bit is set,
  // otherwise go straight to the next shift.
  function automatic state_t step_for(input logic [WIDTH-1:0] m);
    if (m == ZERO) begin
      step_for = S_DONE;
    end else if (m[0]) begin
      step_for = S_ADD;
    end else begin
      step_for = S_SHIFT;
    end
  endfunction

  // Next-state, datapath updates and ALU drive.
  always_comb begin
    state_d       = state_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    prod_d        = prod_q;
    alu_own_c     = 1'b0;
    alu_control_c = OP_ADD;
    alu_src_a_c   = ZERO;
    alu_src_b_c   = ZERO;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          prod_d   = ZERO;
          state_d  = step_for(bus.op_b);
        end
      end

      S_ADD: begin
        alu_own_c     = 1'b1;
        alu_control_c = OP_ADD;
        alu_src_a_c   = prod_q;
        alu_src_b_c   = mcand_q;
        prod_d        = bus.alu_result;
        // The bit just consumed still has to be shifted out.
        state_d       = S_SHIFT;
      end

      S_SHIFT: begin
        alu_own_c     = 1'b1;
        alu_control_c = OP_LS;
        alu_src_a_c   = mcand_q;
        alu_src_b_c   = ONE;
        mcand_d       = bus.alu_result;
        mplier_d      = mplier_q >> 1;
        // Decide on the multiplier as it will be after this shift.
        state_d       = step_for(mplier_d);
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The product is captured on the edge that enters DONE so it is already
  // valid while done is high and stays put until the next completion. When
  // DONE is entered straight from IDLE (op_b == 0) prod_d is the cleared
  // accumulator, which is the correct product.
  always_comb begin
    result_d = result_q;
    if (state_d == S_DONE) begin
      result_d = prod_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      mcand_q  <= ZERO;
      mplier_q <= ZERO;
      prod_q   <= ZERO;
      result_q <= ZERO;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      result_q <= result_d;
    end
  end

  assign bus.ready       = (state_q == S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.result      = result_q;
  assign bus.alu_own     = alu_own_c;
  assign bus.alu_control = alu_control_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;

endmodule

// File: tb/tb_alu_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_seq
//
// Bench for alu_mul_seq. Provides a behavioural ALU, drives directed and
// random multiplications, and compares product, latency, handshake and the
// ALU operation stream against a reference built from the shift-and-add rule.
// -----------------------------------------------------------------------------
module tb_alu_mul_seq;
  localparam int         WIDTH  = 32;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LS  = 4'b0111;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   passed = 0;
  int   total  = 0;

  logic [3:0]  exp_ctrl[$];
  logic [31:0] exp_sa[$];
  logic [31:0] exp_sb[$];

  alu_mul_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .OP_ADD(OP_ADD),
    .OP_LS (OP_LS)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU.
  always_comb begin
    case (bus.alu_control)
      OP_ADD:  bus.alu_result = bus.alu_src_a + bus.alu_src_b;
      OP_LS:   bus.alu_result = bus.alu_src_a << bus.alu_src_b[4:0];
      default: bus.alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected ALU operations for a*b: walk the multiplier bits from LSB to its
  // most significant set bit; a set bit adds the current shifted multiplicand
  // into the running sum, and every bit is followed by one left shift.
  task automatic build_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] acc;
    logic [31:0] mc;
    int msb;
    exp_ctrl.delete();
    exp_sa.delete();
    exp_sb.delete();
    acc = 0;
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    for (int i = 0; i <= msb; i++) begin
      mc = a << i;
      if (b[i]) begin
        exp_ctrl.push_back(OP_ADD); exp_sa.push_back(acc); exp_sb.push_back(mc);
        acc = acc + mc;
      end
      exp_ctrl.push_back(OP_LS); exp_sa.push_back(mc); exp_sb.push_back(32'd1);
    end
  endtask

  // One full multiplication. When hold is set, start stays high with changing
  // operands for the whole operation; those requests must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] exp_prod;
    int k, done_cyc, ndone, step;
    bit seq_ok, busy_ok;
    exp_prod = a * b;
    build_model(a, b);
    k = exp_ctrl.size();
    for (int w = 0; w < 100 && !bus.ready; w++) @(negedge clk);
    chk("ready_before_start", {31'd0, bus.ready}, 32'd1);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1;
    if (hold) begin
      bus.op_a = $urandom;
      bus.op_b = $urandom;
    end else begin
      bus.start = 1'b0;
    end
    done_cyc = -1; ndone = 0; step = 0; seq_ok = 1'b1; busy_ok = 1'b1;
    for (int c = 1; c <= k + 1; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.ready) busy_ok = 1'b0;
      if (bus.alu_own) begin
        if (step >= k) seq_ok = 1'b0;
        else if (bus.alu_control !== exp_ctrl[step] || bus.alu_src_a !== exp_sa[step] ||
                 bus.alu_src_b !== exp_sb[step]) seq_ok = 1'b0;
        step++;
      end
    end
    chk("done_latency", done_cyc, k + 1);
    chk("done_count", ndone, 1);
    chk("alu_own_cycles", step, k);
    chk("alu_sequence", {31'd0, seq_ok}, 32'd1);
    chk("ready_low_while_busy", {31'd0, busy_ok}, 32'd1);
    chk("result_at_done", bus.result, exp_prod);
    chk("alu_idle_in_done", {27'd0, bus.alu_own, bus.alu_control}, {27'd0, 1'b0, OP_ADD});
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    chk("ready_after_done", {31'd0, bus.ready}, 32'd1);
    chk("result_held", bus.result, exp_prod);
  endtask

  initial begin
    int ndone, gap, last, bad;
    logic [31:0] ra, rb;
    bit prev_done;

    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    // Reset state.
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_alu_own", {31'd0, bus.alu_own}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_alu_ctrl", {28'd0, bus.alu_control}, {28'd0, OP_ADD});
    chk("rst_alu_srcs", bus.alu_src_a | bus.alu_src_b, 32'd0);

    // Reset together with start: request must not be taken.
    bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(negedge clk);
    chk("rst_start_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_start_own", {31'd0, bus.alu_own}, 32'd0);
    bus.start = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(32'd7, 32'd6, 1'b0);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd3, 1'b0);
    run_op(32'd3, 32'h8000_0000, 1'b0);
    run_op(32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    chk("mul_all_ones_value", bus.result, 32'hEDCB_A988);

    // Reset in the middle of an operation.
    bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'hFF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
    chk("midrst_alu_own", {31'd0, bus.alu_own}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    resetn = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_op(32'd9, 32'hFF, 1'b0);
    chk("mul_9_ff_value", bus.result, 32'h8F7);

    // Back-to-back with start held high: 2*2 takes 3 ALU cycles, so each
    // product is followed by one IDLE cycle, giving a done every 5 cycles.
    bus.op_a = 32'd2; bus.op_b = 32'd2; bus.start = 1'b1;
    ndone = 0; last = -1; bad = 0; prev_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (prev_done && (bus.done || !bus.ready)) bad++;
      if (bus.done) begin
        if (bus.result !== 32'd4) bad++;
        if (last >= 0 && c - last != 5) bad++;
        last = c;
        ndone++;
      end
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    chk("b2b_done_count", ndone, 8);
    chk("b2b_violations", bad, 0);
    repeat (6) @(negedge clk);

    // Random operations; multiplier is right-shifted by a random amount so
    // that operation lengths vary widely.
    for (int n = 0; n < 25; n++) begin
      ra = $urandom;
      rb = $urandom;
      rb = rb >> $urandom_range(0, 31);
      if (n % 5 == 4) rb = rb & 32'hF;
      run_op(ra, rb, n[0]);
    end

    gap = total - passed;
    if (gap < 0) $error("FAIL counter: got %0d expected 0", gap);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
